// File: rtl/bid_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bid_round_sequencer
// Purpose  : Host-side command sequencer for the three-bidder auction unit.
// Revision : 1.0 - initial release
// ============================================================================
module bid_round_sequencer #(
    parameter logic [31:0] UNLOCK_KEY = 32'h0F0F0F0F,
    parameter int          MAX_WAIT   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [31:0] cfg_xbal,
    input  logic [31:0] cfg_ybal,
    input  logic [31:0] cfg_zbal,
    input  logic [2:0]  cfg_mask,
    input  logic [31:0] cfg_timer,
    input  logic [31:0] cfg_cost,
    output logic [3:0]  C_op,
    output logic [31:0] C_data,
    output logic        C_start,
    input  logic        ready,
    input  logic        roundOver,
    input  logic [1:0]  err,
    input  logic        X_win,
    input  logic        Y_win,
    input  logic        Z_win,
    input  logic [31:0] maxBid,
    output logic        res_valid,
    input  logic        res_ack,
    output logic [1:0]  res_winner,
    output logic [31:0] res_maxBid,
    output logic [1:0]  res_status,
    output logic        busy
);

    localparam int c_wait_w = $clog2(MAX_WAIT + 1);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_cfg    = 3'd1;
    localparam logic [2:0] c_st_run    = 3'd2;
    localparam logic [2:0] c_st_close  = 3'd3;
    localparam logic [2:0] c_st_unlock = 3'd4;
    localparam logic [2:0] c_st_report = 3'd5;

    localparam logic [1:0] c_ph_issue = 2'd0;
    localparam logic [1:0] c_ph_wait  = 2'd1;
    localparam logic [1:0] c_ph_check = 2'd2;

    localparam logic [3:0] c_op_noop   = 4'd0;
    localparam logic [3:0] c_op_unlock = 4'd1;
    localparam logic [3:0] c_op_lock   = 4'd2;
    localparam logic [3:0] c_op_loadx  = 4'd3;
    localparam logic [3:0] c_op_loady  = 4'd4;
    localparam logic [3:0] c_op_loadz  = 4'd5;
    localparam logic [3:0] c_op_mask   = 4'd6;
    localparam logic [3:0] c_op_timer  = 4'd7;
    localparam logic [3:0] c_op_charge = 4'd8;

    localparam logic [2:0] c_last_step = 3'd6;

    logic [2:0]          r_state, w_next_state;
    logic [2:0]          r_step, w_next_step;
    logic [1:0]          r_phase, w_next_phase;
    logic [31:0]         r_timer_cnt, w_next_timer_cnt;
    logic [c_wait_w-1:0] r_wait_cnt, w_next_wait_cnt;
    logic [3:0]          r_c_op, w_next_c_op;
    logic [31:0]         r_c_data, w_next_c_data;
    logic                r_c_start, w_next_c_start;
    logic [1:0]          r_res_winner, w_next_res_winner;
    logic [31:0]         r_res_maxbid, w_next_res_maxbid;
    logic [1:0]          r_res_status, w_next_res_status;

    logic [31:0] r_xbal, r_ybal, r_zbal, r_timer, r_cost;
    logic [2:0]  r_mask;

    logic [2:0]  w_issue_step;
    logic [3:0]  w_issue_op;
    logic [31:0] w_issue_data;
    logic [31:0] w_run_len;
    logic [1:0]  w_winner;

    // From the check phase the op offered is already the following step's.
    assign w_issue_step = (r_phase == c_ph_check) ? r_step + 3'd1 : r_step;
    assign w_run_len    = (r_timer == 32'd0) ? 32'd1 : r_timer;
    assign w_winner     = X_win ? 2'd1 : (Y_win ? 2'd2 : (Z_win ? 2'd3 : 2'd0));

    always_comb begin
        w_issue_op   = c_op_noop;
        w_issue_data = 32'd0;
        case (w_issue_step)
            3'd0: begin w_issue_op = c_op_loadx;  w_issue_data = r_xbal;             end
            3'd1: begin w_issue_op = c_op_loady;  w_issue_data = r_ybal;             end
            3'd2: begin w_issue_op = c_op_loadz;  w_issue_data = r_zbal;             end
            3'd3: begin w_issue_op = c_op_mask;   w_issue_data = {29'd0, r_mask};    end
            3'd4: begin w_issue_op = c_op_timer;  w_issue_data = r_timer;            end
            3'd5: begin w_issue_op = c_op_charge; w_issue_data = r_cost;             end
            3'd6: begin w_issue_op = c_op_lock;   w_issue_data = UNLOCK_KEY;         end
            default: begin w_issue_op = c_op_noop; w_issue_data = 32'd0;             end
        endcase
    end

    always_comb begin
        w_next_state      = r_state;
        w_next_step       = r_step;
        w_next_phase      = r_phase;
        w_next_timer_cnt  = r_timer_cnt;
        w_next_wait_cnt   = r_wait_cnt;
        w_next_c_op       = c_op_noop;
        w_next_c_data     = 32'd0;
        w_next_c_start    = 1'b0;
        w_next_res_winner = r_res_winner;
        w_next_res_maxbid = r_res_maxbid;
        w_next_res_status = r_res_status;
        case (r_state)
            c_st_idle: begin
                if (cfg_valid) begin
                    w_next_state = c_st_cfg;
                    w_next_step  = 3'd0;
                    // LoadX goes out straight from the accepted inputs.
                    if (ready) begin
                        w_next_c_op   = c_op_loadx;
                        w_next_c_data = cfg_xbal;
                        w_next_phase  = c_ph_wait;
                    end else begin
                        w_next_phase  = c_ph_issue;
                    end
                end
            end
            c_st_cfg: begin
                case (r_phase)
                    c_ph_issue: begin
                        if (ready) begin
                            w_next_c_op   = w_issue_op;
                            w_next_c_data = w_issue_data;
                            w_next_phase  = c_ph_wait;
                        end
                    end
                    c_ph_wait: begin
                        w_next_phase = c_ph_check;
                    end
                    default: begin
                        if (err != 2'b00) begin
                            w_next_res_status = 2'd1;
                            w_next_state      = c_st_unlock;
                        end else if (r_step == c_last_step) begin
                            w_next_state     = c_st_run;
                            w_next_timer_cnt = w_run_len;
                            w_next_c_start   = 1'b1;
                        end else begin
                            w_next_step = w_issue_step;
                            if (ready) begin
                                w_next_c_op   = w_issue_op;
                                w_next_c_data = w_issue_data;
                                w_next_phase  = c_ph_wait;
                            end else begin
                                w_next_phase  = c_ph_issue;
                            end
                        end
                    end
                endcase
            end
            c_st_run: begin
                if (r_timer_cnt == 32'd1) begin
                    w_next_state    = c_st_close;
                    w_next_wait_cnt = '0;
                end else begin
                    w_next_timer_cnt = r_timer_cnt - 32'd1;
                    w_next_c_start   = 1'b1;
                end
            end
            c_st_close: begin
                if (roundOver) begin
                    w_next_res_winner = w_winner;
                    w_next_res_maxbid = maxBid;
                    w_next_res_status = 2'd0;
                    w_next_state      = c_st_unlock;
                end else if (r_wait_cnt == c_wait_w'(MAX_WAIT - 1)) begin
                    w_next_res_winner = 2'd0;
                    w_next_res_maxbid = 32'd0;
                    w_next_res_status = 2'd2;
                    w_next_state      = c_st_unlock;
                end else begin
                    w_next_wait_cnt = r_wait_cnt + c_wait_w'(1);
                end
            end
            c_st_unlock: begin
                if (ready) begin
                    w_next_c_op   = c_op_unlock;
                    w_next_c_data = UNLOCK_KEY;
                    w_next_state  = c_st_report;
                end
            end
            c_st_report: begin
                if (res_ack) begin
                    w_next_state = c_st_idle;
                end
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_step       <= 3'd0;
            r_phase      <= c_ph_issue;
            r_timer_cnt  <= 32'd0;
            r_wait_cnt   <= '0;
            r_c_op       <= c_op_noop;
            r_c_data     <= 32'd0;
            r_c_start    <= 1'b0;
            r_res_winner <= 2'd0;
            r_res_maxbid <= 32'd0;
            r_res_status <= 2'd0;
            r_xbal       <= 32'd0;
            r_ybal       <= 32'd0;
            r_zbal       <= 32'd0;
            r_mask       <= 3'd0;
            r_timer      <= 32'd0;
            r_cost       <= 32'd0;
        end else begin
            r_state      <= w_next_state;
            r_step       <= w_next_step;
            r_phase      <= w_next_phase;
            r_timer_cnt  <= w_next_timer_cnt;
            r_wait_cnt   <= w_next_wait_cnt;
            r_c_op       <= w_next_c_op;
            r_c_data     <= w_next_c_data;
            r_c_start    <= w_next_c_start;
            r_res_winner <= w_next_res_winner;
            r_res_maxbid <= w_next_res_maxbid;
            r_res_status <= w_next_res_status;
            if (r_state == c_st_idle && cfg_valid) begin
                r_xbal  <= cfg_xbal;
                r_ybal  <= cfg_ybal;
                r_zbal  <= cfg_zbal;
                r_mask  <= cfg_mask;
                r_timer <= cfg_timer;
                r_cost  <= cfg_cost;
            end
        end
    end

    assign cfg_ready  = (r_state == c_st_idle);
    assign busy       = (r_state != c_st_idle);
    assign res_valid  = (r_state == c_st_report);
    assign C_op       = r_c_op;
    assign C_data     = r_c_data;
    assign C_start    = r_c_start;
    assign res_winner = r_res_winner;
    assign res_maxBid = r_res_maxbid;
    assign res_status = r_res_status;

endmodule
`default_nettype wire

// File: tb/tb_bid_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bid_round_sequencer
// Purpose  : Self-checking bench for bid_round_sequencer with an auction-unit model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bid_round_sequencer;

    localparam logic [31:0] KEY  = 32'h0F0F0F0F;
    localparam int          MAXW = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid, cfg_ready;
    logic [31:0] cfg_xbal, cfg_ybal, cfg_zbal, cfg_timer, cfg_cost;
    logic [2:0]  cfg_mask;
    logic [3:0]  C_op;
    logic [31:0] C_data;
    logic        C_start;
    logic        ready, roundOver;
    logic [1:0]  err;
    logic        X_win, Y_win, Z_win;
    logic [31:0] maxBid;
    logic        res_valid, res_ack;
    logic [1:0]  res_winner, res_status;
    logic [31:0] res_maxBid;
    logic        busy;

    always #5 clk = ~clk;

    bid_round_sequencer #(.UNLOCK_KEY(KEY), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_xbal(cfg_xbal), .cfg_ybal(cfg_ybal), .cfg_zbal(cfg_zbal),
        .cfg_mask(cfg_mask), .cfg_timer(cfg_timer), .cfg_cost(cfg_cost),
        .C_op(C_op), .C_data(C_data), .C_start(C_start),
        .ready(ready), .roundOver(roundOver), .err(err),
        .X_win(X_win), .Y_win(Y_win), .Z_win(Z_win), .maxBid(maxBid),
        .res_valid(res_valid), .res_ack(res_ack),
        .res_winner(res_winner), .res_maxBid(res_maxBid), .res_status(res_status),
        .busy(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Auction-unit model knobs
    logic [3:0] stall_op   = 4'd0;
    int         stall_len  = 0;
    bit         rand_ready = 1'b0;
    logic [3:0] err_op     = 4'd0;
    logic [1:0] err_val    = 2'd0;
    int         ro_delay   = 0;

    // Observations
    logic [3:0]  log_op[$];
    logic [31:0] log_data[$];
    int          start_cnt = 0;
    int          gap_cnt   = 0;
    bit          seen_fall = 1'b0;

    // Results the sequencer should still be holding from the last capture
    logic [1:0]  mdl_winner = 2'd0;
    logic [31:0] mdl_maxbid = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Unit model and bus monitor, evaluated on the falling edge.
    initial begin
        logic [3:0] last_op;
        int  stall_left, ro_cnt;
        bit  armed, prev_start;
        last_op = 4'd0; stall_left = 0; ro_cnt = 0; armed = 1'b0; prev_start = 1'b0;
        ready = 1'b1; err = 2'b00; roundOver = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                last_op = 4'd0; stall_left = 0; armed = 1'b0; prev_start = 1'b0;
                err = 2'b00; roundOver = 1'b0; ready = 1'b1;
                continue;
            end
            if (ready === 1'b0) chk("op_without_ready", {28'd0, C_op}, 32'd0);
            if (C_op != 4'd0) begin
                log_op.push_back(C_op);
                log_data.push_back(C_data);
            end
            if (C_start) start_cnt++;
            if (prev_start && !C_start) seen_fall = 1'b1;
            if (seen_fall && !C_start && !res_valid) gap_cnt++;
            err = (err_op != 4'd0 && last_op == err_op) ? err_val : 2'b00;
            last_op = C_op;
            if (prev_start && !C_start) begin armed = 1'b1; ro_cnt = 0; end
            roundOver = 1'b0;
            if (armed && ro_delay >= 0) begin
                if (ro_cnt == ro_delay) begin roundOver = 1'b1; armed = 1'b0; end
                ro_cnt++;
            end
            prev_start = C_start;
            if (stall_len != 0 && C_op == stall_op) stall_left = stall_len;
            if (stall_left > 0) begin
                ready = 1'b0;
                stall_left--;
            end else begin
                ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    task automatic run_round(input logic [31:0] xb, input logic [31:0] yb, input logic [31:0] zb,
                             input logic [2:0] mask, input logic [31:0] tmr, input logic [31:0] cost,
                             input logic [2:0] flags, input logic [31:0] mb,
                             input int hold_cycles, input bit hold_valid);
        logic [3:0]  ops [7];
        logic [31:0] dat [7];
        logic [3:0]  eo[$];
        logic [31:0] ed[$];
        bit          cerr;
        int          exp_start, n;
        logic [1:0]  ew, es;
        logic [31:0] emb;
        ops = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd2};
        dat = '{xb, yb, zb, {29'd0, mask}, tmr, cost, KEY};
        cerr = 1'b0;
        for (int i = 0; i < 7; i++) begin
            eo.push_back(ops[i]);
            ed.push_back(dat[i]);
            if (ops[i] == err_op && err_val != 2'b00) begin cerr = 1'b1; break; end
        end
        eo.push_back(4'd1);
        ed.push_back(KEY);
        exp_start = cerr ? 0 : ((tmr == 32'd0) ? 1 : int'(tmr));
        if (cerr) begin
            es = 2'd1; ew = mdl_winner; emb = mdl_maxbid;
        end else if (ro_delay < 0) begin
            es = 2'd2; ew = 2'd0; emb = 32'd0;
        end else begin
            es = 2'd0; emb = mb;
            ew = flags[0] ? 2'd1 : (flags[1] ? 2'd2 : (flags[2] ? 2'd3 : 2'd0));
        end

        X_win = flags[0]; Y_win = flags[1]; Z_win = flags[2]; maxBid = mb;
        log_op.delete(); log_data.delete();
        start_cnt = 0; gap_cnt = 0; seen_fall = 1'b0;
        chk("cfg_ready_idle", {31'd0, cfg_ready}, 32'd1);
        cfg_xbal = xb; cfg_ybal = yb; cfg_zbal = zb; cfg_mask = mask;
        cfg_timer = tmr; cfg_cost = cost; cfg_valid = 1'b1;
        @(negedge clk);
        if (!hold_valid) cfg_valid = 1'b0;
        chk("cfg_ready_dropped", {31'd0, cfg_ready}, 32'd0);
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        for (int c = 0; c < 300 && res_valid !== 1'b1; c++) @(negedge clk);
        chk("report_reached", {31'd0, res_valid}, 32'd1);
        if (hold_valid) chk("cfg_ignored_busy", {31'd0, cfg_ready}, 32'd0);

        chk("op_count", log_op.size(), eo.size());
        n = (log_op.size() < eo.size()) ? log_op.size() : eo.size();
        for (int i = 0; i < n; i++) begin
            chk("op_code", {28'd0, log_op[i]}, {28'd0, eo[i]});
            chk("op_data", log_data[i], ed[i]);
        end
        chk("start_cycles", start_cnt, exp_start);
        if (!rand_ready && !cerr)
            chk("close_to_report", gap_cnt, (ro_delay < 0) ? MAXW + 1 : ro_delay + 2);
        chk("res_winner", {30'd0, res_winner}, {30'd0, ew});
        chk("res_maxBid", res_maxBid, emb);
        chk("res_status", {30'd0, res_status}, {30'd0, es});
        for (int c = 0; c < hold_cycles; c++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, res_valid}, 32'd1);
            chk("hold_winner", {30'd0, res_winner}, {30'd0, ew});
            chk("hold_maxBid", res_maxBid, emb);
            chk("hold_status", {30'd0, res_status}, {30'd0, es});
        end
        cfg_valid = 1'b0;
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
        chk("res_valid_after_ack", {31'd0, res_valid}, 32'd0);
        chk("cfg_ready_after_ack", {31'd0, cfg_ready}, 32'd1);
        chk("busy_after_ack", {31'd0, busy}, 32'd0);
        mdl_winner = ew;
        mdl_maxbid = emb;
    endtask

    initial begin
        logic [3:0] op_pick [7];
        op_pick = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd2};
        reset = 1'b1; cfg_valid = 1'b0; res_ack = 1'b0;
        cfg_xbal = 0; cfg_ybal = 0; cfg_zbal = 0; cfg_mask = 0; cfg_timer = 0; cfg_cost = 0;
        X_win = 0; Y_win = 0; Z_win = 0; maxBid = 0;
        repeat (2) @(negedge clk);
        chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        chk("rst_C_op", {28'd0, C_op}, 32'd0);
        chk("rst_C_data", C_data, 32'd0);
        chk("rst_C_start", {31'd0, C_start}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_winner", {30'd0, res_winner}, 32'd0);
        chk("rst_res_maxBid", res_maxBid, 32'd0);
        chk("rst_res_status", {30'd0, res_status}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Basic round, Y wins with 42
        run_round(32'd100, 32'd200, 32'd300, 3'b111, 32'd5, 32'd1, 3'b010, 32'd42, 2, 1'b0);

        // Four-cycle ready stall while LoadY is due
        stall_op = 4'd3; stall_len = 4;
        run_round(32'd11, 32'd22, 32'd33, 3'b101, 32'd3, 32'd2, 3'b001, 32'd77, 1, 1'b0);
        stall_len = 0;

        // Unit rejects SetXYZmask
        err_op = 4'd6; err_val = 2'b10;
        run_round(32'd5, 32'd6, 32'd7, 3'b011, 32'd4, 32'd3, 3'b100, 32'd9, 1, 1'b0);

        // No roundOver; an error reported after Unlock must not disturb the status
        err_op = 4'd1; err_val = 2'b11; ro_delay = -1;
        run_round(32'd1, 32'd2, 32'd3, 3'b111, 32'd2, 32'd1, 3'b001, 32'd55, 10, 1'b0);
        err_op = 4'd0; err_val = 2'b00; ro_delay = 0;

        // Zero-length round with cfg_valid held throughout
        ro_delay = 3;
        run_round(32'd8, 32'd9, 32'd10, 3'b110, 32'd0, 32'd4, 3'b110, 32'd123, 10, 1'b1);
        ro_delay = 0;

        // Asynchronous reset in the middle of RUN
        X_win = 1'b0; Y_win = 1'b0; Z_win = 1'b1; maxBid = 32'd66;
        cfg_xbal = 32'd1; cfg_ybal = 32'd1; cfg_zbal = 32'd1; cfg_mask = 3'b111;
        cfg_timer = 32'd20; cfg_cost = 32'd1; cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        for (int c = 0; c < 40 && C_start !== 1'b1; c++) @(negedge clk);
        chk("run_reached", {31'd0, C_start}, 32'd1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_C_start", {31'd0, C_start}, 32'd0);
        chk("arst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("arst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        chk("arst_C_op", {28'd0, C_op}, 32'd0);
        chk("arst_res_status", {30'd0, res_status}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        mdl_winner = 2'd0; mdl_maxbid = 32'd0;
        log_op.delete(); log_data.delete();
        repeat (5) @(negedge clk);
        chk("no_op_after_reset", log_op.size(), 0);
        chk("idle_after_reset", {31'd0, cfg_ready}, 32'd1);
        run_round(32'd40, 32'd50, 32'd60, 3'b111, 32'd2, 32'd5, 3'b100, 32'd31, 1, 1'b0);

        // Randomized rounds with a jittery ready
        rand_ready = 1'b1;
        for (int r = 0; r < 6; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                err_op  = op_pick[$urandom_range(0, 6)];
                err_val = 2'($urandom_range(1, 3));
            end else begin
                err_op  = 4'd0;
                err_val = 2'd0;
            end
            ro_delay = int'($urandom_range(0, 6)) - 1;
            run_round($urandom, $urandom, $urandom, 3'($urandom_range(0, 7)),
                      32'($urandom_range(0, 6)), $urandom, 3'($urandom_range(0, 7)),
                      $urandom, int'($urandom_range(0, 3)), 1'b0);
        end
        rand_ready = 1'b0; err_op = 4'd0; err_val = 2'd0; ro_delay = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bid_round_sequencer.md
Name: bid_round_sequencer

Overview:
Host-side controller for the three-bidder auction unit (X/Y/Z). It accepts one round configuration per handshake and issues the unit's command sequence: LoadX/Y/Z, SetXYZmask, SetTimer, BidCharge, Lock. It then holds C_start for the programmed round length, closes the round, captures the winner and maxBid, and re-unlocks the unit for the next round.

Parameters:
UNLOCK_KEY, 32'h0F0F0F0F, key driven on C_data with Lock and Unlock ops
MAX_WAIT, 16, cycles allowed for roundOver after C_start drops before timeout

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
cfg_valid  in  1  round configuration offered
cfg_ready  out  1  sequencer idle, accepts configuration
cfg_xbal  in  32  initial X balance (LoadX data)
cfg_ybal  in  32  initial Y balance (LoadY data)
cfg_zbal  in  32  initial Z balance (LoadZ data)
cfg_mask  in  3  bidder enable mask [0]=X [1]=Y [2]=Z
cfg_timer  in  32  round length in cycles
cfg_cost  in  32  per-bid charge (BidCharge data)
C_op  out  4  command opcode to auction unit
C_data  out  32  command data to auction unit
C_start  out  1  round active
ready  in  1  auction unit accepts a command
roundOver  in  1  auction unit result valid
err  in  2  auction unit command error
X_win, Y_win, Z_win  in  1 each  winner flags
maxBid  in  32  winning amount
res_valid  out  1  result held for host
res_ack  in  1  host consumes result
res_winner  out  2  0 none, 1 X, 2 Y, 3 Z
res_maxBid  out  32  captured maxBid
res_status  out  2  0 OK, 1 unit error, 2 timeout
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async): state IDLE; cfg_ready=1, C_op=NoOp(0), C_data=0, C_start=0, res_valid=0, res_winner=0, res_maxBid=0, res_status=0, busy=0; step counter and timer cleared.
- Opcodes: NoOp 0, Unlock 1, Lock 2, LoadX 3, LoadY 4, LoadZ 5, SetXYZmask 6, SetTimer 7, BidCharge 8.
- IDLE: cfg accepted on a cycle where cfg_valid and cfg_ready are both high. All cfg fields are latched. The next state is CFG with step=0, and cfg_ready drops the following cycle.
- CFG: 3-bit step walks LoadX, LoadY, LoadZ, SetXYZmask (C_data={29'b0,mask}), SetTimer, BidCharge, Lock (C_data=UNLOCK_KEY).
  - An op is driven for exactly one cycle, and only in a cycle where ready=1. Otherwise C_op=NoOp and the step holds.
  - After each issued op, C_op=NoOp for one cycle while err is sampled. err!=0 sets res_status=1 and moves to UNLOCK, skipping the remaining ops.
  - After the Lock check passes, go to RUN.
  - Minimum CFG length is 14 cycles with ready held high.
- RUN: C_start=1 for exactly max(cfg_timer,1) cycles, using a down-counter loaded on entry. cfg_timer=0 is treated as 1.
- CLOSE: C_start=0; wait for roundOver with a wait counter.
  - On roundOver=1: capture res_maxBid=maxBid and res_winner from the win flags. Priority is X>Y>Z; no flag gives 0. res_status=0. Go to UNLOCK.
  - If MAX_WAIT cycles elapse with no roundOver: res_status=2, res_winner=0, res_maxBid=0, go to UNLOCK.
- UNLOCK: issue Unlock with C_data=UNLOCK_KEY once ready=1, then go to REPORT. Unlock-phase err is ignored and must not overwrite res_status.
- REPORT: res_valid=1 and results stable until the cycle res_ack=1, then go to IDLE. res_valid=0 next cycle; cfg_ready=1 next cycle.
  - res_ack while res_valid=0 is ignored.
  - res_* hold their last values until the next capture.
- cfg_valid outside IDLE is ignored (no queueing).
- Reset mid-round forces IDLE and drops C_start combinationally with reset; no Unlock is issued.
- The C_op/C_data/C_start outputs are registered.

Test Plan:
- Basic round: cfg bal 100/200/300, mask 3'b111, timer 5, cost 1, ready=1, unit reports Y_win, maxBid 42 -> op order 3,4,5,6,7,8,2 with data 100,200,300,7,5,1,0F0F0F0F; C_start high exactly 5 cycles; Unlock issued; res_winner=2, res_maxBid=42, res_status=0 until res_ack.
- Ready stall: ready=0 for 4 cycles during LoadY -> C_op=NoOp during the stall, LoadY issued once when ready rises, no step skipped or duplicated.
- Config error: err=2'b10 after SetXYZmask -> no SetTimer/BidCharge/Lock issued, C_start never rises, Unlock issued, res_status=1.
- Timeout: roundOver never asserted -> after 16 cycles in CLOSE: res_status=2, res_winner=0, res_maxBid=0, res_valid=1.
- Boundaries: cfg_timer=0 -> C_start high 1 cycle; cfg_valid held during RUN -> ignored; res_valid held 10 cycles without ack -> values stable; next cfg accepted only after ack.
- Async reset asserted mid-RUN -> C_start=0, res_valid=0, cfg_ready=1 immediately; after release a fresh round completes normally.
